// File: rtl/sift_pkg.sv
// Shared widths, luma coefficients and FSM state type
// for the RGB444-to-greyscale pass controller.
package sift_pkg;

  localparam int PIXEL_W = 12;
  localparam int GREY_W  = 8;

  localparam int R_COEF = 5;
  localparam int G_COEF = 9;
  localparam int B_COEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } ctrl_state_t;

  // 15*(5+9+2) = 240 never exceeds 8 bits.
  function automatic logic [GREY_W-1:0] to_grey(
    input logic [PIXEL_W-1:0] px
  );
    logic [GREY_W-1:0] r, g, b;
    r = GREY_W'(px[11:8]);
    g = GREY_W'(px[7:4]);
    b = GREY_W'(px[3:0]);
    return GREY_W'(R_COEF) * r
         + GREY_W'(G_COEF) * g
         + GREY_W'(B_COEF) * b;
  endfunction

endpackage

// File: rtl/rgb444_to_grey.sv
// Registered RGB444 to 8-bit luma stage that
// carries the pixel address alongside the result.
module rgb444_to_grey
  import sift_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic               clk_100mhz,
  input  logic               sys_rst,
  input  logic               valid_in,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic [PIXEL_W-1:0] pixel_in,
  output logic               valid_out,
  output logic [ADDR_W-1:0]  addr_out,
  output logic [GREY_W-1:0]  grey_out
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [GREY_W-1:0] grey_q;

  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      grey_q  <= '0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) begin
        addr_q <= addr_in;
        grey_q <= to_grey(pixel_in);
      end
    end
  end

  assign valid_out = valid_q;
  assign addr_out  = addr_q;
  assign grey_out  = grey_q;

endmodule

// File: rtl/greyscale_pass_ctrl.sv
// Full-frame greyscale pass: issues BRAM reads, tracks
// read latency and writes converted luma back in order.
module greyscale_pass_ctrl
  import sift_pkg::*;
#(
  parameter int H_PIXELS     = 128,
  parameter int V_PIXELS     = 128,
  parameter int READ_LATENCY = 2
) (
  input  logic clk_100mhz,
  input  logic sys_rst,
  input  logic start_in,
  input  logic hold_in,
  output logic busy_out,
  output logic done_out,
  output logic rd_en_out,
  output logic [$clog2(H_PIXELS*V_PIXELS)-1:0] rd_addr_out,
  input  logic [PIXEL_W-1:0] rd_data_in,
  output logic wr_en_out,
  output logic [$clog2(H_PIXELS*V_PIXELS)-1:0] wr_addr_out,
  output logic [GREY_W-1:0] wr_data_out
);

  localparam int NUM_PIXELS = H_PIXELS * V_PIXELS;
  localparam int ADDR_W     = $clog2(NUM_PIXELS);

  ctrl_state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic [READ_LATENCY-1:0] vld_q;
  logic [ADDR_W-1:0]       pa_q [READ_LATENCY];

  logic issue;
  logic last;

  assign issue = (state_q == ISSUE) && !hold_in;
  assign last  = cnt_q == ADDR_W'(NUM_PIXELS - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = ISSUE;
          cnt_d   = '0;
        end
      end
      ISSUE: begin
        if (issue) begin
          if (last) state_d = DRAIN;
          else      cnt_d   = cnt_q + ADDR_W'(1);
        end
      end
      // Convert stage holds at most the final write here.
      DRAIN: begin
        if (vld_q == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vld_q[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++)
        vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk_100mhz) begin
    pa_q[0] <= cnt_q;
    for (int i = 1; i < READ_LATENCY; i++)
      pa_q[i] <= pa_q[i-1];
  end

  rgb444_to_grey #(
    .ADDR_W (ADDR_W)
  ) u_conv (
    .clk_100mhz (clk_100mhz),
    .sys_rst    (sys_rst),
    .valid_in   (vld_q[READ_LATENCY-1]),
    .addr_in    (pa_q[READ_LATENCY-1]),
    .pixel_in   (rd_data_in),
    .valid_out  (wr_en_out),
    .addr_out   (wr_addr_out),
    .grey_out   (wr_data_out)
  );

  assign rd_en_out   = issue;
  assign rd_addr_out = cnt_q;
  assign busy_out    = state_q != IDLE;
  assign done_out    = state_q == DONE;

endmodule

// File: tb/tb_greyscale_pass_ctrl.sv
// Directed bench for greyscale_pass_ctrl with a
// two-cycle image BRAM model and output capture.
module tb_greyscale_pass_ctrl;

  localparam int H   = 128;
  localparam int V   = 32;
  localparam int RL  = 2;
  localparam int NUM = H * V;
  localparam int AW  = $clog2(NUM);

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          start_in = 1'b0;
  logic          hold_in = 1'b0;
  logic          busy_out, done_out;
  logic          rd_en_out, wr_en_out;
  logic [AW-1:0] rd_addr_out, wr_addr_out;
  logic [11:0]   rd_data_in;
  logic [7:0]    wr_data_out;

  always #5 clk = ~clk;

  greyscale_pass_ctrl #(
    .H_PIXELS     (H),
    .V_PIXELS     (V),
    .READ_LATENCY (RL)
  ) dut (
    .clk_100mhz  (clk),
    .sys_rst     (sys_rst),
    .start_in    (start_in),
    .hold_in     (hold_in),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .rd_en_out   (rd_en_out),
    .rd_addr_out (rd_addr_out),
    .rd_data_in  (rd_data_in),
    .wr_en_out   (wr_en_out),
    .wr_addr_out (wr_addr_out),
    .wr_data_out (wr_data_out)
  );

  logic [11:0] img     [NUM];
  logic [7:0]  outm    [NUM];
  logic [7:0]  exp_img [NUM];
  logic [7:0]  ref_run [NUM];
  logic [11:0] d1, d2;

  int cyc = 0;
  int nwr, ord_err, rdhold_err, ndone, exp_wa;
  int done_cyc, first_wr_cyc, first_wr_addr;
  int busy_first, busy_last, busy_cnt;
  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] colours [5] =
    '{12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'h000};
  int greys [5] = '{240, 75, 135, 30, 0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    d1 <= img[rd_addr_out];
    d2 <= d1;
  end
  assign rd_data_in = d2;

  always @(negedge clk) begin
    if (wr_en_out) begin
      if (nwr == 0) begin
        first_wr_cyc  = cyc;
        first_wr_addr = int'(wr_addr_out);
      end
      if (int'(wr_addr_out) != exp_wa) ord_err++;
      exp_wa++;
      nwr++;
      outm[wr_addr_out] = wr_data_out;
    end
    if (rd_en_out && hold_in) rdhold_err++;
    if (done_out) begin
      ndone++;
      done_cyc = cyc;
    end
    if (busy_out) begin
      if (busy_cnt == 0) busy_first = cyc;
      busy_last = cyc;
      busy_cnt++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    nwr = 0; ord_err = 0; rdhold_err = 0;
    ndone = 0; exp_wa = 0; busy_cnt = 0;
    done_cyc = -1; first_wr_cyc = -1;
    first_wr_addr = -1;
    busy_first = -1; busy_last = -1;
    for (int i = 0; i < NUM; i++) outm[i] = 'x;
  endtask

  function automatic int ref_grey(input int i);
    int r, g, b;
    r = (i >> 8) & 15;
    g = (i >> 4) & 15;
    b = i & 15;
    return 5 * r + 9 * g + 2 * b;
  endfunction

  task automatic run_pass(input bit hold_pat,
                          input bit repulse,
                          output int k,
                          output bit got);
    clear_stats();
    @(posedge clk); #1 start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
    k = cyc;
    got = 1'b0;
    for (int i = 0; i < 3 * NUM && !got; i++) begin
      hold_in  = hold_pat && ((cyc % 7) < 3);
      start_in = repulse &&
        (i == 100 || i == NUM + 1 || i == NUM + 3);
      @(negedge clk);
      if (done_out) got = 1'b1;
      @(posedge clk); #1;
    end
    hold_in  = 1'b0;
    start_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  function automatic int frame_errs();
    int e;
    e = 0;
    for (int i = 0; i < NUM; i++)
      if (outm[i] !== exp_img[i]) e++;
    return e;
  endfunction

  task automatic common_checks(input string t, input bit got);
    check({t, "_done_seen"}, got, 1);
    check({t, "_frame"}, frame_errs(), 0);
    check({t, "_nwr"}, nwr, NUM);
    check({t, "_order"}, ord_err, 0);
    check({t, "_ndone"}, ndone, 1);
    check({t, "_idle_after"}, busy_out, 0);
  endtask

  task automatic load_index();
    for (int i = 0; i < NUM; i++) begin
      img[i]     = 12'(i);
      exp_img[i] = 8'(ref_grey(i));
    end
  endtask

  initial begin
    int  k;
    bit  got;
    bit  found;
    int  nwr_at;

    clear_stats();
    for (int i = 0; i < NUM; i++) img[i] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_rd_en", rd_en_out, 0);
    check("rst_rd_addr", rd_addr_out, 0);
    check("rst_wr_en", wr_en_out, 0);
    check("rst_wr_addr", wr_addr_out, 0);
    check("rst_wr_data", wr_data_out, 0);
    @(posedge clk); #1 sys_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_start_busy", busy_out, 0);

    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NUM; i++) begin
        img[i]     = colours[c];
        exp_img[i] = 8'(greys[c]);
      end
      run_pass(1'b0, 1'b0, k, got);
      common_checks($sformatf("colour%0d", c), got);
    end

    load_index();
    run_pass(1'b0, 1'b0, k, got);
    common_checks("index", got);
    check("t_first_wr", first_wr_cyc, k + RL + 1);
    check("t_first_addr", first_wr_addr, 0);
    check("t_done", done_cyc, k + NUM + RL + 1);
    check("t_busy_first", busy_first, k);
    check("t_busy_last", busy_last, k + NUM + RL + 1);
    check("t_busy_cnt", busy_cnt, NUM + RL + 2);
    check("spot_123", outm[12'h123], 29);
    check("spot_888", outm[12'h888], 128);
    check("spot_ABC", outm[12'hABC], 173);
    check("spot_FFF", outm[12'hFFF], 240);
    for (int i = 0; i < NUM; i++) ref_run[i] = outm[i];

    for (int i = 0; i < NUM; i++) exp_img[i] = ref_run[i];
    run_pass(1'b1, 1'b0, k, got);
    common_checks("hold", got);
    check("hold_rd_while_hold", rdhold_err, 0);
    check("hold_longer",
          done_cyc > k + NUM + RL + 1, 1);

    load_index();
    run_pass(1'b0, 1'b1, k, got);
    common_checks("repulse", got);
    check("repulse_done_t", done_cyc, k + NUM + RL + 1);

    run_pass(1'b0, 1'b0, k, got);
    common_checks("second", got);
    check("second_done_t", done_cyc, k + NUM + RL + 1);

    clear_stats();
    @(posedge clk); #1 start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3 * NUM && !found; i++) begin
      @(negedge clk);
      if (wr_en_out && wr_addr_out == AW'(2000))
        found = 1'b1;
    end
    check("mid_reach_2000", found, 1);
    @(posedge clk); #1 sys_rst = 1'b1;
    @(posedge clk); #1 sys_rst = 1'b0;
    @(negedge clk);
    check("mid_wr_en", wr_en_out, 0);
    check("mid_busy", busy_out, 0);
    check("mid_rd_en", rd_en_out, 0);
    check("mid_rd_addr", rd_addr_out, 0);
    nwr_at = nwr;
    repeat (20) @(negedge clk);
    check("mid_no_more_wr", nwr, nwr_at);
    check("mid_no_done", ndone, 0);
    check("mid_still_idle", busy_out, 0);

    run_pass(1'b0, 1'b0, k, got);
    common_checks("post_rst", got);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
